decoder_gpr_unit: RTL and testbench
===================================

DECODER_GPR_UNIT -- requirements
Module: decoder_gpr_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter DATA_W, default 32, SHALL set the instruction, register and PC data width.
REQ-003 Parameter REG_NUM, default 32, SHALL set the GPR count; register addresses are 5 bits.
REQ-004 Ports SHALL be as follows (name  direction  width  meaning):
- clk  in  1  clock
- reset  in  1  asynchronous active-low reset
- we_  in  1  GPR write enable, active-low
- wr_addr  in  5  GPR write address
- wr_data  in  32  GPR write data
- if_insn  in  32  fetched instruction
- if_pc  in  32  PC of if_insn
- if_en  in  1  instruction valid
- gpr_rd_addr_0 / gpr_rd_addr_1  out  5  rs1 / rs2 address
- gpr_rd_data_0 / gpr_rd_data_1  out  32  rs1 / rs2 data
- dst_addr  out  5  rd
- gpr_we_  out  1  writeback enable, active-low
- alu_op  out  4  ALU operation
- alu_in_0 / alu_in_1  out  32  ALU operands
- br_addr  out  32  branch/jump target
- br_taken  out  1  redirect PC
- br_flag  out  1  instruction is a branch or jump
- mem_op  out  4  memory operation
- gpr_data  out  32  store data (rs2)
- ctrl_op  out  2  control operation
- exp_code  out  2  exception code

Function
REQ-005 GPR: REG_NUM x 32 array; when we_=0, wr_data SHALL be written to wr_addr on posedge clk; writes to x0 are ignored, and x0 SHALL read 0.
REQ-006 GPR reads SHALL be combinational, with no write-through bypass; a same-cycle write SHALL become visible after the clock edge.
REQ-007 The decoder SHALL be purely combinational; rs1 = if_insn[19:15] and rs2 = if_insn[24:20] SHALL drive gpr_rd_addr_0/1 unconditionally.
REQ-008 alu_op encodings SHALL be: NOP=0, ADD=1, SUB=2, SLT=3, SLTU=4, XOR=5, OR=6, AND=7, SLL=8, SRL=9, SRA=10.
REQ-009 mem_op encodings SHALL be: NOP=0, LB=1, LH=2, LW=3, LBU=4, LHU=5, SB=6, SH=7, SW=8.
REQ-010 ctrl_op encodings SHALL be: NOP=0, ECALL=1, EBREAK=2; exp_code encodings SHALL be: NONE=0, ILLEGAL=1, ECALL=2, EBREAK=3.
REQ-011 Default outputs SHALL be: gpr_we_=1, alu_op/mem_op/ctrl_op/exp_code=0, br_taken=0, br_flag=0, alu_in_*=0, br_addr=0, dst_addr=rd, gpr_data=rs2 data.
REQ-012 When if_en=0, all decoded outputs SHALL hold their defaults.
REQ-013 OP-IMM SHALL set in0=rs1, in1=sign-extended imm[11:0], and gpr_we_=0; shifts SHALL use in1=zero-extended shamt, with SRAI selected when insn[30]=1.
REQ-014 OP SHALL set in0=rs1 and in1=rs2; SUB/SRA SHALL be selected when insn[30]=1.
REQ-015 LUI SHALL set ADD with in0=0 and in1={imm[31:12],12'b0}; AUIPC SHALL set in0=if_pc with the same in1.
REQ-016 JAL/JALR SHALL set ADD with in0=if_pc, in1=4, gpr_we_=0, br_flag=1 and br_taken=1.
REQ-017 The JAL target SHALL be if_pc+immJ; the JALR target SHALL be (rs1+immI) with bit 0 cleared.
REQ-018 BRANCH (BEQ/BNE/BLT/BGE/BLTU/BGEU) SHALL set br_flag=1, br_addr=if_pc+immB, br_taken=condition(rs1,rs2) and gpr_we_=1; signed/unsigned comparisons SHALL follow RV32I.
REQ-019 LOAD SHALL set ADD with in0=rs1, in1=immI, gpr_we_=0 and mem_op by funct3.
REQ-020 STORE SHALL set ADD with in0=rs1, in1=immS, gpr_we_=1, gpr_data=rs2 and mem_op by funct3.
REQ-021 ECALL/EBREAK SHALL set ctrl_op and exp_code accordingly.
REQ-022 Any unknown opcode or funct SHALL set exp_code=ILLEGAL and gpr_we_=1.
REQ-023 All adders SHALL be 32-bit with modulo-2^32 wrap and no overflow detection.

Reset
REQ-024 reset=0 SHALL asynchronously clear all GPRs to 0; the decoder has no state.

Structure
REQ-025 Opcode, funct3, alu_op, mem_op, ctrl_op and exp_code constants SHALL live in a shared package.
REQ-026 The top level SHALL instantiate one sub-module, gpr_file, with the decoder logic in the top level.

Verification (reset released, then reg i loaded with value i)
REQ-027 ADDI 0xF0168093 -> dst=1, alu_op=ADD, in0=13, in1=0xFFFFFF01, gpr_we_=0.
REQ-028 SRAI 0x40F6D093 -> alu_op=SRA, in0=13, in1=15; ADD 0x01F680B3 -> in0=13, in1=31.
REQ-029 if_pc=5: JAL 0x00A000EF -> br_addr=15, br_taken=1, br_flag=1, dst=1; JALR 0x00B700E7 -> br_addr=24.
REQ-030 if_pc=5, BEQ 0x078C0F63 (rs1=rs2=24) -> br_addr=131, br_taken=1, br_flag=1.
REQ-031 LW 0x03FC2083 -> ADD, in0=24, in1=63, mem_op=LW, dst=1; SW 0x01F420A3 -> in0=8, in1=1, gpr_data=31, mem_op=SW.
REQ-032 Scenario: assert reset mid-run -> all reads return 0; write to x0 -> x0 still reads 0; if_en=0 -> all decoded outputs at defaults.

Source files
------------

// File: rtl/decoder_gpr_unit_pkg.sv
// Shared RV32I encodings: opcodes, funct fields and the operation codes
// the decoder hands to the ALU, memory and control stages.
package decoder_gpr_unit_pkg;

  localparam int REG_ADDR_W = 5;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // ALU funct3
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  // Branch funct3
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Load / store funct3
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [31:0] INSN_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSN_EBREAK = 32'h0010_0073;

  typedef enum logic [3:0] {
    ALU_NOP  = 4'd0,
    ALU_ADD  = 4'd1,
    ALU_SUB  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_OR   = 4'd6,
    ALU_AND  = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10
  } alu_op_e;

  typedef enum logic [3:0] {
    MEM_NOP = 4'd0,
    MEM_LB  = 4'd1,
    MEM_LH  = 4'd2,
    MEM_LW  = 4'd3,
    MEM_LBU = 4'd4,
    MEM_LHU = 4'd5,
    MEM_SB  = 4'd6,
    MEM_SH  = 4'd7,
    MEM_SW  = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    CTRL_NOP    = 2'd0,
    CTRL_ECALL  = 2'd1,
    CTRL_EBREAK = 2'd2
  } ctrl_op_e;

  typedef enum logic [1:0] {
    EXP_NONE    = 2'd0,
    EXP_ILLEGAL = 2'd1,
    EXP_ECALL   = 2'd2,
    EXP_EBREAK  = 2'd3
  } exp_code_e;

endpackage

// File: rtl/decoder_gpr_unit_gpr_file.sv
// General-purpose register file: one write port, two combinational read
// ports, x0 hard-wired to zero, whole file cleared by reset.
module gpr_file
  import decoder_gpr_unit_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_NUM = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we_,
  input  logic [REG_ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [REG_ADDR_W-1:0] rd_addr_0,
  input  logic [REG_ADDR_W-1:0] rd_addr_1,
  output logic [DATA_W-1:0]     rd_data_0,
  output logic [DATA_W-1:0]     rd_data_1
);

  logic [DATA_W-1:0] gpr_q [REG_NUM];

  genvar gi;
  generate
    for (gi = 0; gi < REG_NUM; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        // x0 carries no storage, so writes to it vanish naturally
        assign gpr_q[gi] = '0;
      end else begin : g_word
        logic [DATA_W-1:0] word_reg;
        always_ff @(posedge clk or negedge reset) begin
          if (!reset) begin
            word_reg <= '0;
          end else if (!we_ && (wr_addr == REG_ADDR_W'(gi))) begin
            word_reg <= wr_data;
          end
        end
        assign gpr_q[gi] = word_reg;
      end
    end
  endgenerate

  // No bypass: a write in this cycle shows up only after the clock edge
  assign rd_data_0 = (int'(rd_addr_0) < REG_NUM) ? gpr_q[rd_addr_0] : '0;
  assign rd_data_1 = (int'(rd_addr_1) < REG_NUM) ? gpr_q[rd_addr_1] : '0;

endmodule

// File: rtl/decoder_gpr_unit.sv
// RV32I decode stage: combinational instruction decoder feeding ALU operands,
// branch resolution and memory/control codes, around a GPR file.
module decoder_gpr_unit
  import decoder_gpr_unit_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_NUM = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we_,
  input  logic [REG_ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [DATA_W-1:0]     if_insn,
  input  logic [DATA_W-1:0]     if_pc,
  input  logic                  if_en,
  output logic [REG_ADDR_W-1:0] gpr_rd_addr_0,
  output logic [REG_ADDR_W-1:0] gpr_rd_addr_1,
  output logic [DATA_W-1:0]     gpr_rd_data_0,
  output logic [DATA_W-1:0]     gpr_rd_data_1,
  output logic [REG_ADDR_W-1:0] dst_addr,
  output logic                  gpr_we_,
  output logic [3:0]            alu_op,
  output logic [DATA_W-1:0]     alu_in_0,
  output logic [DATA_W-1:0]     alu_in_1,
  output logic [DATA_W-1:0]     br_addr,
  output logic                  br_taken,
  output logic                  br_flag,
  output logic [3:0]            mem_op,
  output logic [DATA_W-1:0]     gpr_data,
  output logic [1:0]            ctrl_op,
  output logic [1:0]            exp_code
);

  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [DATA_W-1:0] imm_i, imm_s, imm_b, imm_j, imm_u, shamt;
  logic [DATA_W-1:0] rs1_data, rs2_data;
  logic [DATA_W-1:0] jalr_target;
  logic              cond_true;
  logic              illegal;

  assign opcode = if_insn[6:0];
  assign funct3 = if_insn[14:12];
  assign funct7 = if_insn[31:25];

  assign imm_i = DATA_W'($signed(if_insn[31:20]));
  assign imm_s = DATA_W'($signed({if_insn[31:25], if_insn[11:7]}));
  assign imm_b = DATA_W'($signed({if_insn[31], if_insn[7], if_insn[30:25], if_insn[11:8], 1'b0}));
  assign imm_j = DATA_W'($signed({if_insn[31], if_insn[19:12], if_insn[20], if_insn[30:21], 1'b0}));
  assign imm_u = DATA_W'($signed({if_insn[31:12], 12'b0}));
  assign shamt = DATA_W'(if_insn[24:20]);

  assign gpr_rd_addr_0 = if_insn[19:15];
  assign gpr_rd_addr_1 = if_insn[24:20];
  assign gpr_rd_data_0 = rs1_data;
  assign gpr_rd_data_1 = rs2_data;
  assign dst_addr      = if_insn[11:7];
  assign gpr_data      = rs2_data;

  assign jalr_target = (rs1_data + imm_i) & ~DATA_W'(1);

  gpr_file #(
    .DATA_W  (DATA_W),
    .REG_NUM (REG_NUM)
  ) u_gpr_file (
    .clk       (clk),
    .reset     (reset),
    .we_       (we_),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr_0 (gpr_rd_addr_0),
    .rd_addr_1 (gpr_rd_addr_1),
    .rd_data_0 (rs1_data),
    .rd_data_1 (rs2_data)
  );

  always_comb begin
    cond_true = 1'b0;
    case (funct3)
      F3_BEQ:  cond_true = (rs1_data == rs2_data);
      F3_BNE:  cond_true = (rs1_data != rs2_data);
      F3_BLT:  cond_true = ($signed(rs1_data) <  $signed(rs2_data));
      F3_BGE:  cond_true = ($signed(rs1_data) >= $signed(rs2_data));
      F3_BLTU: cond_true = (rs1_data <  rs2_data);
      F3_BGEU: cond_true = (rs1_data >= rs2_data);
      default: cond_true = 1'b0;
    endcase
  end

  always_comb begin
    gpr_we_  = 1'b1;
    alu_op   = ALU_NOP;
    mem_op   = MEM_NOP;
    ctrl_op  = CTRL_NOP;
    exp_code = EXP_NONE;
    alu_in_0 = '0;
    alu_in_1 = '0;
    br_addr  = '0;
    br_taken = 1'b0;
    br_flag  = 1'b0;
    illegal  = 1'b0;

    if (if_en) begin
      case (opcode)
        OPC_OP_IMM: begin
          alu_in_0 = rs1_data;
          alu_in_1 = imm_i;
          gpr_we_  = 1'b0;
          case (funct3)
            F3_ADD_SUB: alu_op = ALU_ADD;
            F3_SLT:     alu_op = ALU_SLT;
            F3_SLTU:    alu_op = ALU_SLTU;
            F3_XOR:     alu_op = ALU_XOR;
            F3_OR:      alu_op = ALU_OR;
            F3_AND:     alu_op = ALU_AND;
            F3_SLL: begin
              alu_op   = ALU_SLL;
              alu_in_1 = shamt;
              illegal  = (funct7 != F7_BASE);
            end
            default: begin
              alu_in_1 = shamt;
              if (funct7 == F7_BASE)     alu_op = ALU_SRL;
              else if (funct7 == F7_ALT) alu_op = ALU_SRA;
              else                       illegal = 1'b1;
            end
          endcase
        end
        OPC_OP: begin
          alu_in_0 = rs1_data;
          alu_in_1 = rs2_data;
          gpr_we_  = 1'b0;
          if (funct7 == F7_BASE) begin
            case (funct3)
              F3_ADD_SUB: alu_op = ALU_ADD;
              F3_SLL:     alu_op = ALU_SLL;
              F3_SLT:     alu_op = ALU_SLT;
              F3_SLTU:    alu_op = ALU_SLTU;
              F3_XOR:     alu_op = ALU_XOR;
              F3_SRL_SRA: alu_op = ALU_SRL;
              F3_OR:      alu_op = ALU_OR;
              default:    alu_op = ALU_AND;
            endcase
          end else if (funct7 == F7_ALT) begin
            case (funct3)
              F3_ADD_SUB: alu_op = ALU_SUB;
              F3_SRL_SRA: alu_op = ALU_SRA;
              default:    illegal = 1'b1;
            endcase
          end else begin
            illegal = 1'b1;
          end
        end
        OPC_LUI: begin
          alu_op   = ALU_ADD;
          alu_in_1 = imm_u;
          gpr_we_  = 1'b0;
        end
        OPC_AUIPC: begin
          alu_op   = ALU_ADD;
          alu_in_0 = if_pc;
          alu_in_1 = imm_u;
          gpr_we_  = 1'b0;
        end
        OPC_JAL, OPC_JALR: begin
          // Link value pc+4 goes through the ALU; the target is resolved here
          alu_op   = ALU_ADD;
          alu_in_0 = if_pc;
          alu_in_1 = DATA_W'(4);
          gpr_we_  = 1'b0;
          br_flag  = 1'b1;
          br_taken = 1'b1;
          br_addr  = (opcode == OPC_JAL) ? (if_pc + imm_j) : jalr_target;
          illegal  = (opcode == OPC_JALR) && (funct3 != 3'b000);
        end
        OPC_BRANCH: begin
          br_flag  = 1'b1;
          br_addr  = if_pc + imm_b;
          br_taken = cond_true;
          illegal  = (funct3 == 3'b010) || (funct3 == 3'b011);
        end
        OPC_LOAD: begin
          alu_op   = ALU_ADD;
          alu_in_0 = rs1_data;
          alu_in_1 = imm_i;
          gpr_we_  = 1'b0;
          case (funct3)
            F3_LB:   mem_op = MEM_LB;
            F3_LH:   mem_op = MEM_LH;
            F3_LW:   mem_op = MEM_LW;
            F3_LBU:  mem_op = MEM_LBU;
            F3_LHU:  mem_op = MEM_LHU;
            default: illegal = 1'b1;
          endcase
        end
        OPC_STORE: begin
          alu_op   = ALU_ADD;
          alu_in_0 = rs1_data;
          alu_in_1 = imm_s;
          case (funct3)
            F3_SB:   mem_op = MEM_SB;
            F3_SH:   mem_op = MEM_SH;
            F3_SW:   mem_op = MEM_SW;
            default: illegal = 1'b1;
          endcase
        end
        OPC_SYSTEM: begin
          if (if_insn[31:0] == INSN_ECALL) begin
            ctrl_op  = CTRL_ECALL;
            exp_code = EXP_ECALL;
          end else if (if_insn[31:0] == INSN_EBREAK) begin
            ctrl_op  = CTRL_EBREAK;
            exp_code = EXP_EBREAK;
          end else begin
            illegal = 1'b1;
          end
        end
        default: illegal = 1'b1;
      endcase

      // An illegal encoding must not leak partial side effects downstream
      if (illegal) begin
        gpr_we_  = 1'b1;
        alu_op   = ALU_NOP;
        mem_op   = MEM_NOP;
        ctrl_op  = CTRL_NOP;
        exp_code = EXP_ILLEGAL;
        alu_in_0 = '0;
        alu_in_1 = '0;
        br_addr  = '0;
        br_taken = 1'b0;
        br_flag  = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_decoder_gpr_unit.sv
// Scoreboard bench for decoder_gpr_unit: expected decode results are queued
// as each instruction is driven and compared when the outputs settle.
module tb_decoder_gpr_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        we_;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [31:0] if_insn;
  logic [31:0] if_pc;
  logic        if_en;
  logic [4:0]  gpr_rd_addr_0, gpr_rd_addr_1, dst_addr;
  logic [31:0] gpr_rd_data_0, gpr_rd_data_1;
  logic        gpr_we_, br_taken, br_flag;
  logic [3:0]  alu_op, mem_op;
  logic [31:0] alu_in_0, alu_in_1, br_addr, gpr_data;
  logic [1:0]  ctrl_op, exp_code;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  ra0, ra1, dst;
    logic        we;
    logic [3:0]  alu, mem;
    logic [31:0] in0, in1, br, rd0, gdata;
    logic        taken, flag;
    logic [1:0]  ctrl, exc;
  } exp_t;

  exp_t        exp_q[$];
  string       name_q[$];
  logic [31:0] model [32];

  decoder_gpr_unit dut (
    .clk           (clk),
    .reset         (reset),
    .we_           (we_),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .if_insn       (if_insn),
    .if_pc         (if_pc),
    .if_en         (if_en),
    .gpr_rd_addr_0 (gpr_rd_addr_0),
    .gpr_rd_addr_1 (gpr_rd_addr_1),
    .gpr_rd_data_0 (gpr_rd_data_0),
    .gpr_rd_data_1 (gpr_rd_data_1),
    .dst_addr      (dst_addr),
    .gpr_we_       (gpr_we_),
    .alu_op        (alu_op),
    .alu_in_0      (alu_in_0),
    .alu_in_1      (alu_in_1),
    .br_addr       (br_addr),
    .br_taken      (br_taken),
    .br_flag       (br_flag),
    .mem_op        (mem_op),
    .gpr_data      (gpr_data),
    .ctrl_op       (ctrl_op),
    .exp_code      (exp_code)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Defaults for an instruction: field-derived addresses, register contents from the model
  function automatic exp_t base(input logic [31:0] insn);
    exp_t e;
    e.ra0 = insn[19:15]; e.ra1 = insn[24:20]; e.dst = insn[11:7];
    e.we = 1'b1; e.alu = 4'd0; e.mem = 4'd0;
    e.in0 = 32'd0; e.in1 = 32'd0; e.br = 32'd0;
    e.rd0 = model[insn[19:15]]; e.gdata = model[insn[24:20]];
    e.taken = 1'b0; e.flag = 1'b0; e.ctrl = 2'd0; e.exc = 2'd0;
    return e;
  endfunction

  task automatic compare_one();
    exp_t  e;
    string n;
    e = exp_q.pop_front();
    n = name_q.pop_front();
    check_val({n, ".rd_addr_0"}, 32'(gpr_rd_addr_0), 32'(e.ra0));
    check_val({n, ".rd_addr_1"}, 32'(gpr_rd_addr_1), 32'(e.ra1));
    check_val({n, ".rd_data_0"}, gpr_rd_data_0, e.rd0);
    check_val({n, ".rd_data_1"}, gpr_rd_data_1, e.gdata);
    check_val({n, ".dst_addr"},  32'(dst_addr), 32'(e.dst));
    check_val({n, ".gpr_we_"},   32'(gpr_we_), 32'(e.we));
    check_val({n, ".alu_op"},    32'(alu_op), 32'(e.alu));
    check_val({n, ".alu_in_0"},  alu_in_0, e.in0);
    check_val({n, ".alu_in_1"},  alu_in_1, e.in1);
    check_val({n, ".br_addr"},   br_addr, e.br);
    check_val({n, ".br_taken"},  32'(br_taken), 32'(e.taken));
    check_val({n, ".br_flag"},   32'(br_flag), 32'(e.flag));
    check_val({n, ".mem_op"},    32'(mem_op), 32'(e.mem));
    check_val({n, ".gpr_data"},  gpr_data, e.gdata);
    check_val({n, ".ctrl_op"},   32'(ctrl_op), 32'(e.ctrl));
    check_val({n, ".exp_code"},  32'(exp_code), 32'(e.exc));
  endtask

  task automatic send(input string nm, input logic [31:0] insn, input logic [31:0] pc,
                      input logic en, input exp_t e, input logic wn = 1'b1,
                      input logic [4:0] wa = 5'd0, input logic [31:0] wd = 32'd0);
    @(posedge clk);
    #1;
    if_insn = insn; if_pc = pc; if_en = en;
    we_ = wn; wr_addr = wa; wr_data = wd;
    exp_q.push_back(e);
    name_q.push_back(nm);
    $display("TXN %s insn=0x%08h pc=0x%08h en=%0b we_=%0b", nm, insn, pc, en, wn);
    @(negedge clk);
    compare_one();
    if (!wn && wa != 5'd0) model[wa] = wd;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    we_ = 1'b0; wr_addr = a; wr_data = d;
    @(posedge clk);
    #1;
    we_ = 1'b1;
    if (a != 5'd0) model[a] = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    reset = 1'b0; we_ = 1'b1; wr_addr = 5'd0; wr_data = 32'd0;
    if_insn = 32'd0; if_pc = 32'd0; if_en = 1'b0;

    // Reset state: every register reads zero
    e = base(32'h01F680B3); e.we = 1'b0; e.alu = 4'd1;
    send("RST_ADD", 32'h01F680B3, 32'd0, 1'b1, e);

    @(negedge clk); reset = 1'b1;
    for (int i = 1; i < 32; i++) wr(5'(i), 32'(i));
    wr(5'd0, 32'hDEAD_BEEF);

    e = base(32'hF0168093); e.we = 0; e.alu = 4'd1; e.in0 = 32'd13; e.in1 = 32'hFFFF_FF01;
    send("ADDI", 32'hF0168093, 32'd5, 1'b1, e);
    e = base(32'h40F6D093); e.we = 0; e.alu = 4'd10; e.in0 = 32'd13; e.in1 = 32'd15;
    send("SRAI", 32'h40F6D093, 32'd5, 1'b1, e);
    e = base(32'h01F680B3); e.we = 0; e.alu = 4'd1; e.in0 = 32'd13; e.in1 = 32'd31;
    send("ADD", 32'h01F680B3, 32'd5, 1'b1, e);
    e = base(32'h41F680B3); e.we = 0; e.alu = 4'd2; e.in0 = 32'd13; e.in1 = 32'd31;
    send("SUB", 32'h41F680B3, 32'd5, 1'b1, e);
    e = base(32'h00A000EF); e.we = 0; e.alu = 4'd1; e.in0 = 32'd5; e.in1 = 32'd4;
    e.br = 32'd15; e.taken = 1; e.flag = 1;
    send("JAL", 32'h00A000EF, 32'd5, 1'b1, e);
    e = base(32'h00B700E7); e.we = 0; e.alu = 4'd1; e.in0 = 32'd5; e.in1 = 32'd4;
    e.br = 32'd24; e.taken = 1; e.flag = 1;
    send("JALR", 32'h00B700E7, 32'd5, 1'b1, e);
    e = base(32'h078C0F63); e.br = 32'd131; e.taken = 1; e.flag = 1;
    send("BEQ", 32'h078C0F63, 32'd5, 1'b1, e);
    e = base(32'h078C1F63); e.br = 32'd131; e.taken = 0; e.flag = 1;
    send("BNE", 32'h078C1F63, 32'd5, 1'b1, e);
    e = base(32'h0020E463); e.br = 32'd13; e.taken = 1; e.flag = 1;
    send("BLTU_1_2", 32'h0020E463, 32'd5, 1'b1, e);
    e = base(32'h03FC2083); e.we = 0; e.alu = 4'd1; e.in0 = 32'd24; e.in1 = 32'd63; e.mem = 4'd3;
    send("LW", 32'h03FC2083, 32'd5, 1'b1, e);
    e = base(32'h01F420A3); e.alu = 4'd1; e.in0 = 32'd8; e.in1 = 32'd1; e.mem = 4'd8;
    send("SW", 32'h01F420A3, 32'd5, 1'b1, e);
    e = base(32'h123450B7); e.we = 0; e.alu = 4'd1; e.in1 = 32'h1234_5000;
    send("LUI", 32'h123450B7, 32'd5, 1'b1, e);
    e = base(32'h12345097); e.we = 0; e.alu = 4'd1; e.in0 = 32'd5; e.in1 = 32'h1234_5000;
    send("AUIPC", 32'h12345097, 32'd5, 1'b1, e);
    e = base(32'h00000073); e.ctrl = 2'd1; e.exc = 2'd2;
    send("ECALL", 32'h00000073, 32'd5, 1'b1, e);
    e = base(32'h00100073); e.ctrl = 2'd2; e.exc = 2'd3;
    send("EBREAK", 32'h00100073, 32'd5, 1'b1, e);
    e = base(32'hFFFFFFFF); e.exc = 2'd1;
    send("ILL_OPC", 32'hFFFFFFFF, 32'd5, 1'b1, e);
    e = base(32'h03F680B3); e.exc = 2'd1;
    send("ILL_MUL", 32'h03F680B3, 32'd5, 1'b1, e);
    e = base(32'hF0168093);
    send("EN_OFF", 32'hF0168093, 32'd5, 1'b0, e);

    // Same-cycle write is not bypassed; it appears after the edge
    e = base(32'h01F680B3); e.we = 0; e.alu = 4'd1; e.in0 = 32'd13; e.in1 = 32'd31;
    send("WR_SAME", 32'h01F680B3, 32'd5, 1'b1, e, 1'b0, 5'd13, 32'h77);
    e = base(32'h01F680B3); e.we = 0; e.alu = 4'd1; e.in0 = 32'h77; e.in1 = 32'd31;
    send("WR_AFTER", 32'h01F680B3, 32'd5, 1'b1, e);

    wr(5'd30, 32'hFFFF_FFFF);
    e = base(32'h001F4463); e.br = 32'd13; e.taken = 1; e.flag = 1;
    send("BLT_NEG", 32'h001F4463, 32'd5, 1'b1, e);
    e = base(32'h001F6463); e.br = 32'd13; e.taken = 0; e.flag = 1;
    send("BLTU_NEG", 32'h001F6463, 32'd5, 1'b1, e);

    // Mid-run reset clears the file asynchronously
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    e = base(32'h01F680B3); e.we = 0; e.alu = 4'd1;
    send("MID_RST", 32'h01F680B3, 32'd5, 1'b1, e);
    @(negedge clk); reset = 1'b1;

    e = base(32'h00100093); e.we = 0; e.alu = 4'd1; e.in1 = 32'd1;
    send("X0_WR", 32'h00100093, 32'd5, 1'b1, e, 1'b0, 5'd0, 32'hDEAD_BEEF);
    e = base(32'h00100093); e.we = 0; e.alu = 4'd1; e.in1 = 32'd1;
    send("X0_RD", 32'h00100093, 32'd5, 1'b1, e);

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
